// File: rtl/huffman_param.sv
// Parametrised Huffman encoder: counts symbols 1..NSYM over a gray_valid frame, then
// builds one code per symbol with NSYM-1 pairwise merges of the two lightest live nodes.
module huffman_param #(
    parameter int unsigned NSYM   = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned HC_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gray_valid,
    input  logic [DATA_W-1:0]     gray_data,
    output logic                  CNT_valid,
    output logic [NSYM*CNT_W-1:0] CNT,
    output logic                  code_valid,
    output logic [NSYM*HC_W-1:0]  HC,
    output logic [NSYM*HC_W-1:0]  M
);
    localparam int unsigned IW = $clog2(NSYM);
    localparam int unsigned WW = CNT_W + 4;
    localparam int unsigned LW = $clog2(HC_W + 1);

    typedef enum logic [2:0] {StIdle, StCount, StReport, StSelect, StMerge, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NSYM];
    logic [CNT_W-1:0]  cnt_d [NSYM];
    logic [HC_W-1:0]   hc_q  [NSYM];
    logic [HC_W-1:0]   hc_d  [NSYM];
    logic [HC_W-1:0]   m_q   [NSYM];
    logic [HC_W-1:0]   m_d   [NSYM];
    logic [LW-1:0]     len_q [NSYM];
    logic [LW-1:0]     len_d [NSYM];
    logic [WW-1:0]     w_q   [NSYM];
    logic [WW-1:0]     w_d   [NSYM];
    logic [IW-1:0]     id_q  [NSYM];
    logic [IW-1:0]     id_d  [NSYM];
    logic [NSYM-1:0]   mem_q [NSYM];
    logic [NSYM-1:0]   mem_d [NSYM];
    logic [NSYM-1:0]   live_q, live_d;
    logic [IW-1:0]     lo_q, lo_d, hi_q, hi_d, step_q, step_d;
    logic [IW-1:0]     lo_sel, hi_sel;
    logic              lo_ok, hi_ok;
    logic              cnt_valid_q, cnt_valid_d, code_valid_q, code_valid_d;

    // Lightest live node, then lightest of the rest; equal weights favour the higher group id.
    always_comb begin
        lo_sel = '0;
        hi_sel = '0;
        lo_ok  = 1'b0;
        hi_ok  = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            if (live_q[i] && (!lo_ok || w_q[i] < w_q[lo_sel] ||
                              (w_q[i] == w_q[lo_sel] && id_q[i] > id_q[lo_sel]))) begin
                lo_sel = IW'(i);
                lo_ok  = 1'b1;
            end
        end
        for (int i = 0; i < NSYM; i++) begin
            if (live_q[i] && IW'(i) != lo_sel &&
                (!hi_ok || w_q[i] < w_q[hi_sel] ||
                 (w_q[i] == w_q[hi_sel] && id_q[i] > id_q[hi_sel]))) begin
                hi_sel = IW'(i);
                hi_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hc_d         = hc_q;
        m_d          = m_q;
        len_d        = len_q;
        w_d          = w_q;
        id_d         = id_q;
        mem_d        = mem_q;
        live_d       = live_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        step_d       = step_q;
        cnt_valid_d  = 1'b0;
        code_valid_d = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (gray_valid) begin
                    for (int i = 0; i < NSYM; i++) begin
                        cnt_d[i] = (gray_data == DATA_W'(i + 1)) ? CNT_W'(1) : '0;
                        hc_d[i]  = '0;
                        m_d[i]   = '0;
                    end
                    state_d = StCount;
                end else begin
                    state_d = StIdle;
                end
            end
            StCount: begin
                if (gray_valid) begin
                    for (int i = 0; i < NSYM; i++) begin
                        if (gray_data == DATA_W'(i + 1) && cnt_q[i] != '1) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end else begin
                    cnt_valid_d = 1'b1;
                    state_d     = StReport;
                end
            end
            StReport: begin
                for (int i = 0; i < NSYM; i++) begin
                    w_d[i]   = WW'(cnt_q[i]);
                    id_d[i]  = IW'(i);
                    mem_d[i] = NSYM'(1) << i;
                    len_d[i] = '0;
                    hc_d[i]  = '0;
                end
                live_d  = '1;
                step_d  = '0;
                state_d = StSelect;
            end
            StSelect: begin
                lo_d    = lo_sel;
                hi_d    = hi_sel;
                state_d = StMerge;
            end
            StMerge: begin
                // Prepend a bit to every member code: 0 for the hi group, 1 for the lo group.
                for (int s = 0; s < NSYM; s++) begin
                    if (mem_q[lo_q][s]) begin
                        hc_d[s] = hc_q[s] | (HC_W'(1) << len_q[s]);
                    end
                    if (mem_q[lo_q][s] || mem_q[hi_q][s]) begin
                        len_d[s] = len_q[s] + 1'b1;
                    end
                end
                w_d[hi_q]   = w_q[hi_q] + w_q[lo_q];
                id_d[hi_q]  = (id_q[lo_q] < id_q[hi_q]) ? id_q[lo_q] : id_q[hi_q];
                mem_d[hi_q] = mem_q[hi_q] | mem_q[lo_q];
                live_d[lo_q] = 1'b0;
                if (step_q == IW'(NSYM - 2)) begin
                    for (int s = 0; s < NSYM; s++) begin
                        m_d[s] = ~({HC_W{1'b1}} << len_d[s]);
                    end
                    code_valid_d = 1'b1;
                    state_d      = StDone;
                end else begin
                    step_d  = step_q + 1'b1;
                    state_d = StSelect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            live_q       <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            step_q       <= '0;
            cnt_valid_q  <= 1'b0;
            code_valid_q <= 1'b0;
            for (int i = 0; i < NSYM; i++) begin
                cnt_q[i] <= '0;
                hc_q[i]  <= '0;
                m_q[i]   <= '0;
                len_q[i] <= '0;
                w_q[i]   <= '0;
                id_q[i]  <= '0;
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            live_q       <= live_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            step_q       <= step_d;
            cnt_valid_q  <= cnt_valid_d;
            code_valid_q <= code_valid_d;
            cnt_q        <= cnt_d;
            hc_q         <= hc_d;
            m_q          <= m_d;
            len_q        <= len_d;
            w_q          <= w_d;
            id_q         <= id_d;
            mem_q        <= mem_d;
        end
    end

    always_comb begin
        CNT = '0;
        HC  = '0;
        M   = '0;
        for (int i = 0; i < NSYM; i++) begin
            CNT[i*CNT_W +: CNT_W] = cnt_q[i];
            HC[i*HC_W +: HC_W]    = hc_q[i];
            M[i*HC_W +: HC_W]     = m_q[i];
        end
    end

    assign CNT_valid  = cnt_valid_q;
    assign code_valid = code_valid_q;

endmodule

// File: tb/tb_huffman_param.sv
// Bench for huffman_param: a 6-symbol and a 2-symbol instance driven with directed and
// random frames, compared against a queue-based Huffman reference model.
module tb_huffman_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        gv_a, gv_b, cv_a, cv_b, kv_a, kv_b;
    logic [7:0]  gd_a, gd_b;
    logic [47:0] cnt_a, hc_a, m_a;
    logic [15:0] cnt_b, hc_b, m_b;
    int          tests = 0;
    int          fails = 0;
    int          cnts[8];

    always #5 clk = ~clk;

    huffman_param #(.NSYM(6)) dut_a (
        .clk(clk), .reset(reset), .gray_valid(gv_a), .gray_data(gd_a),
        .CNT_valid(cv_a), .CNT(cnt_a), .code_valid(kv_a), .HC(hc_a), .M(m_a)
    );

    huffman_param #(.NSYM(2)) dut_b (
        .clk(clk), .reset(reset), .gray_valid(gv_b), .gray_data(gd_b),
        .CNT_valid(cv_b), .CNT(cnt_b), .code_valid(kv_b), .HC(hc_b), .M(m_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int gid(input int mem);
        for (int s = 0; s < 8; s++) if (((mem >> s) & 1) != 0) return s;
        return 99;
    endfunction

    // Reference: repeatedly merge the two lightest groups of a node list.
    function automatic void model(input int n, output logic [63:0] e_cnt,
                                  output logic [63:0] e_hc, output logic [63:0] e_m);
        int w[$];
        int mem[$];
        int code[8];
        int len[8];
        int lo, hi, c;
        e_cnt = '0;
        e_hc  = '0;
        e_m   = '0;
        for (int s = 0; s < n; s++) begin
            c = (cnts[s] > 255) ? 255 : cnts[s];
            e_cnt |= 64'(c) << (8 * s);
            w.push_back(c);
            mem.push_back(1 << s);
            code[s] = 0;
            len[s]  = 0;
        end
        while (w.size() > 1) begin
            lo = 0;
            for (int i = 1; i < w.size(); i++)
                if (w[i] < w[lo] || (w[i] == w[lo] && gid(mem[i]) > gid(mem[lo]))) lo = i;
            hi = (lo == 0) ? 1 : 0;
            for (int i = 0; i < w.size(); i++)
                if (i != lo && (w[i] < w[hi] || (w[i] == w[hi] && gid(mem[i]) > gid(mem[hi]))))
                    hi = i;
            for (int s = 0; s < n; s++) begin
                if (((mem[lo] >> s) & 1) != 0) begin
                    code[s] |= 1 << len[s];
                    len[s]++;
                end
                if (((mem[hi] >> s) & 1) != 0) len[s]++;
            end
            w[hi]   += w[lo];
            mem[hi] |= mem[lo];
            w.delete(lo);
            mem.delete(lo);
        end
        for (int s = 0; s < n; s++) begin
            e_hc |= 64'(code[s]) << (8 * s);
            e_m  |= 64'((1 << len[s]) - 1) << (8 * s);
        end
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            gv_b = v;
            gd_b = d;
        end else begin
            gv_a = v;
            gd_a = d;
        end
    endtask

    // Called at a negedge; sends one frame from cnts[] plus junk samples and checks results.
    task automatic run_frame(input bit sel, input int n, input int junk, input bit stray,
                             input bit abort);
        int          q[$];
        int          tmp, j, k, k_cnt, n_cnt, n_kv;
        bit          done;
        logic [63:0] e_cnt, e_hc, e_m, o_cnt, o_hc, o_m;
        logic        cv, kv;
        string       t;
        t = sel ? "b" : "a";
        model(n, e_cnt, e_hc, e_m);
        for (int s = 0; s < n; s++) repeat (cnts[s]) q.push_back(s + 1);
        for (int i = 0; i < junk; i++) q.push_back((i % 3 == 0) ? 0 : ((i % 3 == 1) ? n + 1 : 255));
        for (int i = q.size() - 1; i > 0; i--) begin
            j    = $urandom_range(i, 0);
            tmp  = q[i];
            q[i] = q[j];
            q[j] = tmp;
        end
        foreach (q[i]) begin
            drive(sel, 1'b1, 8'(q[i]));
            @(negedge clk);
        end
        drive(sel, 1'b0, 8'd0);
        k     = 0;
        k_cnt = -100;
        n_cnt = 0;
        done  = 1'b0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
            cv    = sel ? cv_b : cv_a;
            kv    = sel ? kv_b : kv_a;
            o_cnt = sel ? 64'(cnt_b) : 64'(cnt_a);
            o_hc  = sel ? 64'(hc_b) : 64'(hc_a);
            o_m   = sel ? 64'(m_b) : 64'(m_a);
            if (cv) begin
                n_cnt++;
                k_cnt = k;
                check({t, ":CNT"}, o_cnt, e_cnt);
            end
            if (abort && k == k_cnt + 6) begin
                reset = 1'b0;
                #1;
                check({t, ":rst CNT"}, sel ? 64'(cnt_b) : 64'(cnt_a), 64'd0);
                check({t, ":rst HC"}, sel ? 64'(hc_b) : 64'(hc_a), 64'd0);
                check({t, ":rst M"}, sel ? 64'(m_b) : 64'(m_a), 64'd0);
                check({t, ":rst valids"}, {62'd0, cv_a | cv_b, kv_a | kv_b}, 64'd0);
                repeat (2) @(negedge clk);
                reset = 1'b1;
                n_kv  = 0;
                repeat (30) begin
                    @(negedge clk);
                    if (kv_a || kv_b) n_kv++;
                end
                check({t, ":no code_valid after reset"}, 64'(n_kv), 64'd0);
                return;
            end
            if (kv) begin
                done = 1'b1;
                check({t, ":code latency"}, 64'(k - k_cnt), 64'(2 * (n - 1) + 1));
                check({t, ":CNT_valid pulses"}, 64'(n_cnt), 64'd1);
                check({t, ":CNT hold"}, o_cnt, e_cnt);
                check({t, ":HC"}, o_hc, e_hc);
                check({t, ":M"}, o_m, e_m);
            end else if (stray && k_cnt > 0) begin
                drive(sel, 1'($urandom_range(1, 0)), 8'($urandom_range(n, 1)));
            end
        end
        check({t, ":code_valid seen"}, 64'(done), 64'd1);
        drive(sel, 1'b0, 8'd0);
    endtask

    initial begin
        int total;
        reset = 1'b0;
        gv_a  = 1'b0;
        gv_b  = 1'b0;
        gd_a  = '0;
        gd_b  = '0;
        repeat (3) @(negedge clk);
        check("reset a outputs", {cnt_a, 14'd0, cv_a, kv_a}, 64'd0);
        check("reset a HC/M", {16'd0, hc_a | m_a}, 64'd0);
        check("reset b outputs", {cnt_b, hc_b, m_b, 14'd0, cv_b, kv_b}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // T1
        cnts = '{10, 20, 30, 15, 5, 20, 0, 0};
        run_frame(1'b0, 6, 0, 1'b0, 1'b0);
        check("T1 CNT", 64'(cnt_a), 64'h14050F1E140A);
        check("T1 HC", 64'(hc_a), 64'h030101010200);
        check("T1 M", 64'(m_a), 64'h030F0703030F);

        // T2
        cnts = '{1, 1, 1, 1, 1, 1, 0, 0};
        run_frame(1'b0, 6, 0, 1'b0, 1'b0);
        check("T2 HC", 64'(hc_a), 64'h030201000302);
        check("T2 M", 64'(m_a), 64'h070707070303);

        // T3
        cnts = '{3, 7, 0, 0, 0, 0, 0, 0};
        run_frame(1'b1, 2, 0, 1'b0, 1'b0);
        check("T3 HC", 64'(hc_b), 64'h0001);
        check("T3 M", 64'(m_b), 64'h0101);

        // T4: saturation with ignored values mixed in
        cnts = '{300, 0, 0, 0, 0, 0, 0, 0};
        run_frame(1'b0, 6, 30, 1'b0, 1'b0);
        check("T4 CNT", 64'(cnt_a), 64'hFF);

        // T5: reset during third merge, then a clean T1 frame
        cnts = '{10, 20, 30, 15, 5, 20, 0, 0};
        run_frame(1'b0, 6, 0, 1'b0, 1'b1);
        run_frame(1'b0, 6, 0, 1'b0, 1'b0);
        check("T5 HC", 64'(hc_a), 64'h030101010200);
        check("T5 M", 64'(m_a), 64'h030F0703030F);

        // T6: stray samples during merge, second frame starts in DONE
        run_frame(1'b0, 6, 0, 1'b1, 1'b0);
        run_frame(1'b0, 6, 0, 1'b0, 1'b0);
        check("T6 CNT", 64'(cnt_a), 64'h14050F1E140A);
        check("T6 HC", 64'(hc_a), 64'h030101010200);
        check("T6 M", 64'(m_a), 64'h030F0703030F);

        // Random frames on both instances
        for (int r = 0; r < 10; r++) begin
            total = 0;
            for (int s = 0; s < 8; s++) begin
                cnts[s] = (s < 6) ? int'($urandom_range(40, 0)) : 0;
                total  += cnts[s];
            end
            if (total == 0) cnts[0] = 1;
            run_frame(1'b0, 6, int'($urandom_range(6, 0)), 1'($urandom_range(1, 0)), 1'b0);
        end
        for (int r = 0; r < 4; r++) begin
            cnts    = '{0, 0, 0, 0, 0, 0, 0, 0};
            cnts[0] = $urandom_range(20, 1);
            cnts[1] = $urandom_range(20, 0);
            run_frame(1'b1, 2, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
